// File: rtl/ibus_responder_pkg.sv
// Shared pipeline types for the instruction-bus responder: fetch request/response
// structs and the responder state encoding.
package ibus_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ibus_rsp_state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ibus_responder.sv
// Single-outstanding instruction-bus responder: forwards aligned fetches to a
// backend read port, answers misaligned fetches with zero, and forces a response on timeout.
module ibus_responder
  import ibus_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  output logic        mreq_valid,
  output logic [31:0] mreq_addr,
  input  logic        mreq_ready,
  input  logic        mresp_valid,
  input  logic [31:0] mresp_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ibus_rsp_state_t state, state_next;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;
  logic [CW-1:0]   count_q;
  logic            cnt_expired;

  assign cnt_expired = (count_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a backend response in the last WAIT cycle beats the timeout
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ireq.valid) begin
          state_next = is_misaligned(ireq.addr) ? ST_RESP : ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mreq_ready) begin
          state_next = ST_WAIT;
        end else begin
          state_next = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mresp_valid || cnt_expired) begin
          state_next = ST_RESP;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Address/data capture, timeout counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      count_q     <= {CW{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ireq.valid) begin
            addr_q <= ireq.addr;
            data_q <= 32'd0;
          end
        end
        ST_ISSUE: begin
          if (mreq_ready) begin
            count_q <= {CW{1'b0}};
          end
        end
        ST_WAIT: begin
          if (mresp_valid) begin
            data_q <= mresp_data;
          end else if (cnt_expired) begin
            data_q      <= 32'd0;
            timeout_err <= 1'b1;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs; everything handed to fetch/backend is held low while reset is asserted
  always_comb begin
    iresp      = '0;
    mreq_valid = 1'b0;
    mreq_addr  = addr_q;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  iresp.addr_ok = resetn & ireq.valid;
      ST_ISSUE: mreq_valid    = resetn;
      ST_RESP: begin
        iresp.data_ok = resetn;
        iresp.data    = resetn ? data_q : 32'd0;
      end
      default: begin
        iresp      = '0;
        mreq_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder (TIMEOUT_CYCLES = 4) with hand-computed expectations.
module tb_ibus_responder;
  import ibus_responder_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        mreq_valid;
  logic [31:0] mreq_addr;
  logic        mreq_ready;
  logic        mresp_valid;
  logic [31:0] mresp_data;
  logic        busy;
  logic        timeout_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_hs    = 0;

  always #5 clk = ~clk;

  ibus_responder #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_ready(mreq_ready),
    .mresp_valid(mresp_valid), .mresp_data(mresp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Count backend handshakes
  always @(posedge clk) begin
    if (resetn && mreq_valid && mreq_ready) n_hs <= n_hs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Move to the next cycle: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Full aligned read with immediate ready and response; returns in the data_ok cycle
  task automatic run_read(input string tag, input logic [31:0] a, input logic [31:0] d);
    ireq = '{valid: 1'b1, addr: a};
    settle();
    check({tag, "_addr_ok"}, 32'(iresp.addr_ok), 32'd1);
    tick();
    ireq.valid = 1'b0; mreq_ready = 1'b1;
    settle();
    check({tag, "_mreq_valid"}, 32'(mreq_valid), 32'd1);
    check({tag, "_mreq_addr"}, mreq_addr, a);
    tick();
    mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = d;
    settle();
    check({tag, "_no_early_data_ok"}, 32'(iresp.data_ok), 32'd0);
    tick();
    mresp_valid = 1'b0; mresp_data = 32'd0;
    settle();
    check({tag, "_data_ok"}, 32'(iresp.data_ok), 32'd1);
    check({tag, "_data"}, iresp.data, d);
  endtask

  initial begin
    int hs0;
    resetn = 1'b0; ireq = '{valid: 1'b1, addr: 32'hBFC0_0000};
    mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_data = 32'd0;
    tick(); tick();
    settle();
    check("rst_addr_ok", 32'(iresp.addr_ok), 32'd0);
    check("rst_data_ok", 32'(iresp.data_ok), 32'd0);
    check("rst_mreq_valid", 32'(mreq_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    ireq.valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // Aligned read
    hs0 = n_hs;
    run_read("aligned", 32'hBFC0_0000, 32'h2402_0001);
    tick();
    settle();
    check("aligned_data_ok_once", 32'(iresp.data_ok), 32'd0);
    check("aligned_data_zero", iresp.data, 32'd0);
    check("aligned_idle_busy", 32'(busy), 32'd0);
    check("aligned_handshakes", 32'(n_hs - hs0), 32'd1);

    // Misaligned read
    hs0 = n_hs;
    ireq = '{valid: 1'b1, addr: 32'hBFC0_0002};
    settle();
    check("mis_addr_ok", 32'(iresp.addr_ok), 32'd1);
    tick();
    ireq.valid = 1'b0;
    settle();
    check("mis_mreq_valid", 32'(mreq_valid), 32'd0);
    check("mis_data_ok", 32'(iresp.data_ok), 32'd1);
    check("mis_data", iresp.data, 32'd0);
    tick();
    settle();
    check("mis_done", 32'(iresp.data_ok), 32'd0);
    check("mis_no_handshake", 32'(n_hs - hs0), 32'd0);

    // Backpressure: ready low 5 cycles, fetch keeps valid high
    ireq = '{valid: 1'b1, addr: 32'h8000_0010};
    tick();
    for (int i = 0; i < 6; i++) begin
      mreq_ready = (i == 5);
      settle();
      check("bp_mreq_valid", 32'(mreq_valid), 32'd1);
      check("bp_mreq_addr", mreq_addr, 32'h8000_0010);
      check("bp_addr_ok", 32'(iresp.addr_ok), 32'd0);
      tick();
    end
    mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 32'h1111_2222;
    settle();
    check("bp_wait_addr_ok", 32'(iresp.addr_ok), 32'd0);
    tick();
    mresp_valid = 1'b0; ireq.valid = 1'b0;
    settle();
    check("bp_data_ok", 32'(iresp.data_ok), 32'd1);
    check("bp_data", iresp.data, 32'h1111_2222);
    tick();

    // Response coincides with the last allowed WAIT cycle: data wins
    ireq = '{valid: 1'b1, addr: 32'h0000_0200};
    tick();
    ireq.valid = 1'b0; mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    tick(); tick(); tick();
    mresp_valid = 1'b1; mresp_data = 32'h5A5A_A5A5;
    tick();
    mresp_valid = 1'b0;
    settle();
    check("race_data_ok", 32'(iresp.data_ok), 32'd1);
    check("race_data", iresp.data, 32'h5A5A_A5A5);
    check("race_no_timeout", 32'(timeout_err), 32'd0);
    tick();

    // Timeout with no response
    ireq = '{valid: 1'b1, addr: 32'h0000_0100};
    tick();
    ireq.valid = 1'b0; mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("to_wait_no_data_ok", 32'(iresp.data_ok), 32'd0);
      check("to_wait_busy", 32'(busy), 32'd1);
      tick();
    end
    settle();
    check("to_data_ok", 32'(iresp.data_ok), 32'd1);
    check("to_data", iresp.data, 32'd0);
    check("to_err_set", 32'(timeout_err), 32'd1);
    tick();
    mresp_valid = 1'b1; mresp_data = 32'hDEAD_BEEF;
    tick();
    mresp_valid = 1'b0;
    settle();
    check("to_late_ignored", 32'(iresp.data_ok), 32'd0);
    check("to_late_idle", 32'(busy), 32'd0);
    run_read("to_next", 32'h0000_0104, 32'hCAFE_F00D);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    tick();

    // Reset while waiting for the backend
    ireq = '{valid: 1'b1, addr: 32'h0000_0300};
    tick();
    ireq.valid = 1'b0; mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0; resetn = 1'b0;
    settle();
    check("rw_rst_data_ok", 32'(iresp.data_ok), 32'd0);
    tick();
    resetn = 1'b1;
    settle();
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_err_cleared", 32'(timeout_err), 32'd0);
    mresp_valid = 1'b1; mresp_data = 32'h0BAD_0BAD;
    tick();
    mresp_valid = 1'b0;
    settle();
    check("rw_stale_ignored", 32'(iresp.data_ok), 32'd0);
    check("rw_stale_idle", 32'(busy), 32'd0);
    run_read("rw_next", 32'h0000_0304, 32'h1234_5678);
    tick();

    // Back-to-back requests
    hs0 = n_hs;
    run_read("b2b_a", 32'h0000_0400, 32'hAAAA_0001);
    tick();
    run_read("b2b_b", 32'h0000_0404, 32'hBBBB_0002);
    tick();
    check("b2b_handshakes", 32'(n_hs - hs0), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ibus_responder.md
IBUS_RESPONDER -- requirements
Module: ibus_responder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles spent in WAIT before a forced response (range 2..1023).
REQ-002 Ports (clock and reset first): clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, synchronous and active-low.
REQ-004 ireq  in  ibus_req_t  instruction-bus request (valid, addr[31:0]) from the fetch stage.
REQ-005 iresp  out  ibus_resp_t  response (addr_ok, data_ok, data[31:0]) to the fetch stage.
REQ-006 mreq_valid  out  1  backend read request valid.
REQ-007 mreq_addr  out  32  backend word address.
REQ-008 mreq_ready  in  1  backend accepts request this cycle.
REQ-009 mresp_valid  in  1  backend read data valid, one-cycle pulse.
REQ-010 mresp_data  in  32  backend read data.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 timeout_err  out  1  sticky flag, set on any forced timeout response.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, RESP; one outstanding request at a time.
REQ-014 IDLE: iresp.addr_ok = ireq.valid (combinational); on acceptance, ireq.addr is latched into addr_q.
REQ-015 IDLE accept, addr_q[1:0] != 0 -> RESP with data_q = 0; no backend request issued.
REQ-016 IDLE accept, aligned -> ISSUE.
REQ-017 ISSUE: mreq_valid = 1, mreq_addr = addr_q held stable; mreq_ready = 1 -> WAIT, counter cleared to 0.
REQ-018 mresp_valid is honoured only in WAIT; pulses in any other state are discarded.
REQ-019 WAIT: mresp_valid = 1 -> data_q = mresp_data, go to RESP.
REQ-020 WAIT with no response: counter increments each cycle; counter == TIMEOUT_CYCLES-1 -> data_q = 0, timeout_err = 1, go to RESP.
REQ-021 Simultaneous mresp_valid and timeout in WAIT: the real data wins and timeout_err is not set.
REQ-022 RESP: iresp.data_ok = 1 for exactly one cycle, iresp.data = data_q; then IDLE.
REQ-023 iresp.addr_ok = 0 outside IDLE, so a new request is accepted no earlier than the cycle after data_ok.
REQ-024 iresp.data = 0 whenever data_ok = 0.
REQ-025 Counter width: clog2(TIMEOUT_CYCLES) + 1 bits, unsigned, no wrap (the FSM exits first).
REQ-026 Latency, aligned request with mreq_ready = 1 immediately and mresp_valid on the first WAIT cycle: addr_ok at cycle 0, data_ok at cycle 3.
REQ-027 Latency, misaligned request: addr_ok at cycle 0, data_ok at cycle 1.

Reset
REQ-028 resetn = 0 at a rising edge sets state IDLE, addr_q/data_q/counter 0, and timeout_err 0.
REQ-029 During reset, mreq_valid and all iresp fields are 0.
REQ-030 Reset mid-transaction abandons it with no data_ok; backend responses after reset are discarded per REQ-018.

Structure
REQ-031 ibus_req_t/ibus_resp_t come from the shared pipeline header; a state enum ibus_rsp_state_t is added to the shared package.
REQ-032 Single module, no sub-modules; the timeout counter stays inline.

Verification
REQ-033 Aligned read: ireq{1, 0xBFC00000}, mreq_ready = 1 at cycle 1, mresp_valid with 0x24020001 at cycle 2 -> addr_ok cycle 0, mreq_addr = 0xBFC00000 cycle 1, data_ok with data 0x24020001 cycle 3 only.
REQ-034 Misaligned read: ireq{1, 0xBFC00002} -> addr_ok cycle 0, mreq_valid never 1, data_ok with data 0 cycle 1.
REQ-035 Backpressure: mreq_ready low for 5 cycles -> mreq_valid and mreq_addr stable for 6 cycles, addr_ok 0 throughout, data_ok after the response.
REQ-036 Timeout: TIMEOUT_CYCLES = 4, no mresp_valid -> data_ok with data 0 on the 5th cycle after entering WAIT, timeout_err = 1 and stays 1; a late mresp_valid pulse is ignored and the next request returns its own data.
REQ-037 Reset in WAIT: resetn low 1 cycle -> no data_ok, busy = 0; a stale mresp_valid pulse is ignored; the next request completes normally.
REQ-038 Back-to-back: ireq.valid reasserted in the cycle after data_ok -> addr_ok that cycle, and exactly one mreq_valid handshake per request.
